// File: rtl/traffic_light_xing_if.sv
// Request/mode inputs, lamp drives and countdown display for the xing controller.
interface traffic_light_xing_if #(
  parameter int unsigned CNT_W = 8
);
  logic             pass_request;
  logic             night_mode;
  logic [CNT_W-1:0] clock;
  logic             main_red;
  logic             main_yellow;
  logic             main_green;
  logic             side_red;
  logic             side_yellow;
  logic             side_green;
  logic             ped_pending;

  modport master (
    output pass_request, night_mode,
    input  clock, main_red, main_yellow, main_green,
           side_red, side_yellow, side_green, ped_pending
  );

  modport slave (
    input  pass_request, night_mode,
    output clock, main_red, main_yellow, main_green,
           side_red, side_yellow, side_green, ped_pending
  );
endinterface

// File: rtl/traffic_light_xing.sv
// Two-road signal controller: main/side phases with all-red clearance,
// pedestrian shortening of main green and flashing-yellow night mode.
module traffic_light_xing #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned MAIN_T   = 60,
  parameter int unsigned SIDE_T   = 10,
  parameter int unsigned YEL_T    = 5,
  parameter int unsigned ALLRED_T = 2,
  parameter int unsigned PED_T    = 10,
  parameter int unsigned FLASH_T  = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  traffic_light_xing_if.slave bus
);

  localparam longint unsigned MAX_D = (64'd1 << CNT_W) - 64'd1;

  if (CNT_W < 1 || CNT_W > 32 ||
      MAIN_T < 1 || MAIN_T > MAX_D || SIDE_T < 1 || SIDE_T > MAX_D ||
      YEL_T < 1 || YEL_T > MAX_D || ALLRED_T < 1 || ALLRED_T > MAX_D ||
      PED_T < 1 || PED_T > MAX_D || FLASH_T < 1 || FLASH_T > MAX_D) begin : g_bad_param
    $error("traffic_light_xing: phase durations must lie in 1..2^CNT_W-1");
  end

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ALLRED_B = 3'd1;
  localparam logic [2:0] MAIN_GRN = 3'd2;
  localparam logic [2:0] MAIN_YEL = 3'd3;
  localparam logic [2:0] ALLRED_A = 3'd4;
  localparam logic [2:0] SIDE_GRN = 3'd5;
  localparam logic [2:0] SIDE_YEL = 3'd6;
  localparam logic [2:0] NIGHT    = 3'd7;

  // Lamp vector order: {main_r, main_y, main_g, side_r, side_y, side_g}
  localparam logic [5:0] LMP_OFF = 6'b000_000;
  localparam logic [5:0] LMP_AR  = 6'b100_100;
  localparam logic [5:0] LMP_MG  = 6'b001_100;
  localparam logic [5:0] LMP_MY  = 6'b010_100;
  localparam logic [5:0] LMP_SG  = 6'b100_001;
  localparam logic [5:0] LMP_SY  = 6'b100_010;
  localparam logic [5:0] LMP_NY  = 6'b010_010;

  logic [2:0]       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             flash_on, flash_d;
  logic             ped_q, ped_d;
  logic [5:0]       lamp_q, lamp_d;
  logic             req, last;

  assign req  = bus.pass_request | ped_q;
  assign last = (cnt == CNT_W'(1));

  always_comb begin
    state_d = state;
    cnt_d   = cnt - CNT_W'(1);
    flash_d = flash_on;
    case (state)
      IDLE: begin
        state_d = ALLRED_B;
        cnt_d   = CNT_W'(ALLRED_T);
      end
      ALLRED_B: if (last) begin
        if (bus.night_mode) begin
          state_d = NIGHT;
          cnt_d   = CNT_W'(FLASH_T);
          flash_d = 1'b1;
        end else begin
          state_d = MAIN_GRN;
          cnt_d   = req ? CNT_W'(PED_T) : CNT_W'(MAIN_T);
        end
      end
      MAIN_GRN: begin
        if (last) begin
          state_d = MAIN_YEL;
          cnt_d   = CNT_W'(YEL_T);
        end else if (req && cnt > CNT_W'(PED_T)) begin
          cnt_d = CNT_W'(PED_T);
        end
      end
      MAIN_YEL: if (last) begin
        state_d = ALLRED_A;
        cnt_d   = CNT_W'(ALLRED_T);
      end
      ALLRED_A: if (last) begin
        if (bus.night_mode) begin
          state_d = NIGHT;
          cnt_d   = CNT_W'(FLASH_T);
          flash_d = 1'b1;
        end else begin
          state_d = SIDE_GRN;
          cnt_d   = CNT_W'(SIDE_T);
        end
      end
      SIDE_GRN: if (last) begin
        state_d = SIDE_YEL;
        cnt_d   = CNT_W'(YEL_T);
      end
      SIDE_YEL: if (last) begin
        state_d = ALLRED_B;
        cnt_d   = CNT_W'(ALLRED_T);
      end
      NIGHT: if (last) begin
        // Night mode is only left at the end of a dark half-period
        cnt_d = CNT_W'(FLASH_T);
        if (flash_on) begin
          flash_d = 1'b0;
        end else if (!bus.night_mode) begin
          state_d = ALLRED_B;
          cnt_d   = CNT_W'(ALLRED_T);
        end else begin
          flash_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Served once side green is granted; anything seen during night is dropped
  assign ped_d = req & ~(state == ALLRED_A && last) & ~(state == NIGHT);

  always_comb begin
    lamp_d = LMP_OFF;
    case (state_d)
      ALLRED_B, ALLRED_A: lamp_d = LMP_AR;
      MAIN_GRN:           lamp_d = LMP_MG;
      MAIN_YEL:           lamp_d = LMP_MY;
      SIDE_GRN:           lamp_d = LMP_SG;
      SIDE_YEL:           lamp_d = LMP_SY;
      NIGHT:              lamp_d = flash_d ? LMP_NY : LMP_OFF;
      default:            lamp_d = LMP_OFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      flash_on <= 1'b0;
      ped_q    <= 1'b0;
      lamp_q   <= '0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      flash_on <= flash_d;
      ped_q    <= ped_d;
      lamp_q   <= lamp_d;
    end
  end

  assign bus.clock       = cnt;
  assign bus.ped_pending = ped_q;
  assign {bus.main_red, bus.main_yellow, bus.main_green,
          bus.side_red, bus.side_yellow, bus.side_green} = lamp_q;

endmodule

// File: tb/tb_traffic_light_xing.sv
// Directed bench for traffic_light_xing: phase timing, pedestrian, night, reset.
module tb_traffic_light_xing;

  localparam int unsigned CNT_W = 8;

  localparam logic [5:0] L_OFF = 6'b000_000;
  localparam logic [5:0] L_AR  = 6'b100_100;
  localparam logic [5:0] L_MG  = 6'b001_100;
  localparam logic [5:0] L_MY  = 6'b010_100;
  localparam logic [5:0] L_SG  = 6'b100_001;
  localparam logic [5:0] L_SY  = 6'b100_010;
  localparam logic [5:0] L_NY  = 6'b010_010;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [5:0]  lamps;

  traffic_light_xing_if #(.CNT_W(CNT_W)) bus ();

  traffic_light_xing #(
    .CNT_W(CNT_W), .MAIN_T(60), .SIDE_T(10), .YEL_T(5),
    .ALLRED_T(2), .PED_T(10), .FLASH_T(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  assign lamps = {bus.main_red, bus.main_yellow, bus.main_green,
                  bus.side_red, bus.side_yellow, bus.side_green};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  function automatic logic lamps_ok();
    return ($countones(lamps[5:3]) <= 1) && ($countones(lamps[2:0]) <= 1) &&
           !(lamps[3] && lamps[0]);
  endfunction

  task automatic look(input string tag, input logic [5:0] lamp, input int val, input logic ped);
    chk({tag, ".clock"}, 32'(bus.clock), 32'(val));
    chk({tag, ".lamps"}, 32'(lamps), 32'(lamp));
    chk({tag, ".ped"},   32'(bus.ped_pending), 32'(ped));
    chk({tag, ".excl"},  32'(lamps_ok()), 32'd1);
  endtask

  task automatic phase(input string tag, input logic [5:0] lamp, input int from,
                       input int to, input logic ped);
    for (int k = from; k >= to; k--) begin
      look(tag, lamp, k, ped);
      cyc();
    end
  endtask

  task automatic req_pulse();
    bus.pass_request = 1'b1;
    cyc();
    bus.pass_request = 1'b0;
  endtask

  task automatic full_cycle(input string tag);
    phase({tag, ".ab"}, L_AR, 2, 1, 1'b0);
    phase({tag, ".mg"}, L_MG, 60, 1, 1'b0);
    phase({tag, ".my"}, L_MY, 5, 1, 1'b0);
    phase({tag, ".aa"}, L_AR, 2, 1, 1'b0);
    phase({tag, ".sg"}, L_SG, 10, 1, 1'b0);
    phase({tag, ".sy"}, L_SY, 5, 1, 1'b0);
  endtask

  initial begin
    bus.pass_request = 1'b0;
    bus.night_mode   = 1'b0;
    rst_n            = 1'b0;
    repeat (2) cyc();
    look("rst", L_OFF, 0, 1'b0);
    rst_n = 1'b1;
    cyc();

    // default sequence, 84-cycle period
    full_cycle("seq");

    // request at main green 40 shortens to PED_T
    phase("p40.ab", L_AR, 2, 1, 1'b0);
    phase("p40.mg", L_MG, 60, 41, 1'b0);
    look("p40.at", L_MG, 40, 1'b0);
    req_pulse();
    phase("p40.mg2", L_MG, 10, 1, 1'b1);
    phase("p40.my", L_MY, 5, 1, 1'b1);
    phase("p40.aa", L_AR, 2, 1, 1'b1);
    phase("p40.sg", L_SG, 10, 1, 1'b0);
    phase("p40.sy", L_SY, 5, 1, 1'b0);

    // request at 7: no shortening, served at side green entry
    phase("p7.ab", L_AR, 2, 1, 1'b0);
    phase("p7.mg", L_MG, 60, 8, 1'b0);
    look("p7.at", L_MG, 7, 1'b0);
    req_pulse();
    phase("p7.mg2", L_MG, 6, 1, 1'b1);
    phase("p7.my", L_MY, 5, 1, 1'b1);
    phase("p7.aa", L_AR, 2, 1, 1'b1);
    phase("p7.sg", L_SG, 10, 1, 1'b0);
    phase("p7.sy", L_SY, 5, 1, 1'b0);

    // next main green is full length; request during side green
    phase("ps.ab", L_AR, 2, 1, 1'b0);
    phase("ps.mg", L_MG, 60, 1, 1'b0);
    phase("ps.my", L_MY, 5, 1, 1'b0);
    phase("ps.aa", L_AR, 2, 1, 1'b0);
    phase("ps.sg", L_SG, 10, 6, 1'b0);
    look("ps.at", L_SG, 5, 1'b0);
    req_pulse();
    phase("ps.sg2", L_SG, 4, 1, 1'b1);
    phase("ps.sy", L_SY, 5, 1, 1'b1);
    phase("ps.ab2", L_AR, 2, 1, 1'b1);
    phase("ps.mg2", L_MG, 10, 1, 1'b1);
    phase("ps.my2", L_MY, 5, 1, 1'b1);
    phase("ps.aa2", L_AR, 2, 1, 1'b1);
    phase("ps.sg3", L_SG, 10, 1, 1'b0);
    phase("ps.sy3", L_SY, 5, 1, 1'b0);

    // night mode raised mid main green, takes effect after ALLRED_A
    phase("nt.ab", L_AR, 2, 1, 1'b0);
    phase("nt.mg", L_MG, 60, 31, 1'b0);
    look("nt.at", L_MG, 30, 1'b0);
    bus.night_mode = 1'b1;
    cyc();
    phase("nt.mg2", L_MG, 29, 1, 1'b0);
    phase("nt.my", L_MY, 5, 1, 1'b0);
    phase("nt.aa", L_AR, 2, 1, 1'b0);
    phase("nt.on1", L_NY, 4, 1, 1'b0);
    phase("nt.off1", L_OFF, 4, 1, 1'b0);
    look("nt.on2a", L_NY, 4, 1'b0);
    req_pulse();
    phase("nt.on2", L_NY, 3, 1, 1'b0);
    bus.night_mode = 1'b0;
    phase("nt.off2", L_OFF, 4, 1, 1'b0);
    phase("nt.ab2", L_AR, 2, 1, 1'b0);
    phase("nt.mg3", L_MG, 60, 1, 1'b0);
    phase("nt.my3", L_MY, 5, 1, 1'b0);
    phase("nt.aa3", L_AR, 2, 1, 1'b0);

    // async reset during side yellow with a pending request
    phase("rs.sg", L_SG, 10, 4, 1'b0);
    look("rs.at", L_SG, 3, 1'b0);
    req_pulse();
    phase("rs.sg2", L_SG, 2, 1, 1'b1);
    phase("rs.sy", L_SY, 5, 3, 1'b1);
    #2 rst_n = 1'b0;
    #1 look("rs.async", L_OFF, 0, 1'b0);
    cyc();
    look("rs.hold", L_OFF, 0, 1'b0);
    rst_n = 1'b1;
    cyc();
    phase("rs.ab", L_AR, 2, 1, 1'b0);
    phase("rs.mg", L_MG, 60, 55, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/traffic_light_xing.md
# traffic_light_xing

Two-road intersection signal controller: main road and side road, each with red/yellow/green lamps, all-red clearance intervals, a latched pedestrian request that shortens main green, and a flashing-yellow night mode. All phase durations and the countdown width are parameters. It drives the lamp outputs and a countdown display bus directly from registered state, and sits between the board-level request/mode inputs and the lamp drivers.

## Interface
- CNT_W, 8, width of countdown counter and `clock` output
- MAIN_T, 60, main-road green duration (cycles)
- SIDE_T, 10, side-road green duration
- YEL_T, 5, yellow duration (both roads)
- ALLRED_T, 2, all-red clearance duration
- PED_T, 10, main green remaining after a pedestrian request
- FLASH_T, 4, night-mode half-period (yellow on, then off)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- pass_request  in  1  pedestrian request, sampled each cycle, any length
- night_mode  in  1  level; high requests flashing-yellow operation
- clock  out  CNT_W  remaining cycles in current phase
- main_red, main_yellow, main_green  out  1 each  main-road lamps
- side_red, side_yellow, side_green  out  1 each  side-road lamps
- ped_pending  out  1  latched, not-yet-served pedestrian request

## Operation
- States: IDLE, ALLRED_B, MAIN_GRN, MAIN_YEL, ALLRED_A, SIDE_GRN, SIDE_YEL, NIGHT.
- Every phase has duration D: on entry `clock` loads D, decrements by 1 per cycle; in the cycle `clock`==1 the FSM advances and `clock` loads the next D. A phase therefore lasts exactly D cycles, `clock` showing D..1.
- Sequence: IDLE (1 cycle, `clock`=0) -> ALLRED_B (ALLRED_T) -> MAIN_GRN (MAIN_T) -> MAIN_YEL (YEL_T) -> ALLRED_A (ALLRED_T) -> SIDE_GRN (SIDE_T) -> SIDE_YEL (YEL_T) -> ALLRED_B. Default period 84 cycles.
- Lamps (Moore): MAIN_GRN main_green+side_red; MAIN_YEL main_yellow+side_red; SIDE_GRN side_green+main_red; SIDE_YEL side_yellow+main_red; ALLRED_A/B both red; IDLE all off; NIGHT both yellows on during first FLASH_T cycles of each period, all off for the next FLASH_T.
- Never more than one of red/yellow/green on per road; never green on both roads.
- Pedestrian: req = pass_request | ped_pending. ped_pending next = req & ~(state==ALLRED_A & `clock`==1) & ~(state==NIGHT). In MAIN_GRN, if req and `clock` > PED_T, `clock` loads PED_T next cycle. On entry to MAIN_GRN with req, `clock` loads PED_T instead of MAIN_T. Request with `clock` <= PED_T: no change; stays pending until served.
- Night: sampled at the `clock`==1 cycle of ALLRED_A or ALLRED_B; if high, next state NIGHT instead of the green. NIGHT reloads FLASH_T each half-period; at the end of an off half-period with night_mode low, go to ALLRED_B. Requests in NIGHT are discarded.
- Arithmetic: all durations 1..2^CNT_W-1, elaboration check; counter never underflows.

## Timing
- Reset (async assert, sync-released by upstream): state IDLE, `clock`=0, all lamps 0, ped_pending 0. First clk edge after release: ALLRED_B, `clock`=ALLRED_T, both red.
- Lamps and `clock` are registered; they change on the same edge as the state.
- Request to shortened `clock`: 1 cycle (request at cycle n, `clock`=PED_T at n+1).
- Reset mid-phase: immediate return to reset values regardless of state; pending request lost.
- night_mode toggling mid-phase has no effect until the next sample point.

## Test plan
- Reset release, idle inputs -> ALLRED_B 2, MAIN_GRN 60, MAIN_YEL 5, ALLRED_A 2, SIDE_GRN 10, SIDE_YEL 5; period 84; lamp exclusivity checked every cycle.
- One-cycle pass_request at MAIN_GRN `clock`=40 -> `clock`=10 next cycle, MAIN_YEL 10 cycles later, ped_pending clears at ALLRED_A->SIDE_GRN.
- pass_request at MAIN_GRN `clock`=7 -> green ends normally at 1; ped_pending stays 1 until SIDE_GRN entry; next MAIN_GRN loads MAIN_T.
- pass_request during SIDE_GRN -> ped_pending 1; next MAIN_GRN entry loads `clock`=10.
- night_mode high during MAIN_GRN -> normal until end of ALLRED_A, then yellows flash 4 on/4 off; night_mode low -> ALLRED_B after off half, then MAIN_GRN 60.
- rst_n low during SIDE_YEL with ped_pending 1 -> all outputs 0 asynchronously; restart sequence from ALLRED_B.
